// File: rtl/rec_ctrl_mt_pkg.sv
// rec_pkg: shared definitions for the multi-track recorder controller.
// State encoding (also the value of the 'state' output), keypad codes and
// the one-hot LED decode helper.
package rec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_READY      = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5,
    ST_FWD        = 3'd6,
    ST_BWD        = 3'd7
  } state_e;

  localparam logic [3:0] KEY_ON    = 4'h1;  // ON / STOP
  localparam logic [3:0] KEY_PAUSE = 4'h2;
  localparam logic [3:0] KEY_CLEAR = 4'h3;  // CLEAR in READY, FWD while playing
  localparam logic [3:0] KEY_BACK  = 4'h4;
  localparam logic [3:0] KEY_TRACK = 4'h5;  // TRACK_NEXT
  localparam logic [3:0] KEY_NONE  = 4'hF;

  function automatic logic [7:0] led_onehot(input state_e s);
    return 8'b0000_0001 << s;
  endfunction

endpackage

// File: rtl/rec_ctrl_mt_key_oneshot.sv
// key_oneshot: turns a level keypad code into a single-cycle accept.
//   clk, rst   : clock, synchronous active-high reset
//   value      : raw keypad code, 4'hF = no key
//   key_valid  : high for the one cycle a key is accepted
//   key_code   : the accepted code (meaningful when key_valid)
// A key is accepted in the first cycle value != 4'hF while armed; any key
// activity disarms, and a cycle with no key re-arms.
module key_oneshot
  import rec_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  output logic       key_valid,
  output logic [3:0] key_code
);

  logic armed_q, armed_d;

  always_comb begin
    key_valid = armed_q && (value != KEY_NONE);
    key_code  = value;
    armed_d   = armed_q;
    if (value == KEY_NONE) begin
      armed_d = 1'b1;
    end else if (key_valid) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/rec_ctrl_mt.sv
// rec_ctrl_mt: multi-track recorder/player controller.
//   clk, rst : clock, synchronous active-high reset
//   value    : keypad code (1 ON/STOP, 2 PAUSE, 3 CLEAR/FWD, 4 BACK,
//              5 TRACK_NEXT, 4'hF none)
//   tick     : one-cycle sample strobe
//   wr_en    : write the sample at addr (recording)
//   rd_en    : read the sample at addr (playing / seeking)
//   addr     : sample address within the current track
//   track    : current track index
//   speed    : log2 of the seek step (0 outside FWD/BWD)
//   done     : one-cycle pulse, playback/seek reached a track boundary
//   clr      : one-cycle pulse, current track erased
//   state    : encoded state, led : one-hot of state
// MAX_SPD_LOG2 must fit the 2-bit speed output (<= 3).
module rec_ctrl_mt
  import rec_pkg::*;
#(
  parameter  int ADDR_W       = 12,
  parameter  int N_TRACKS     = 4,
  parameter  int MAX_SPD_LOG2 = 2,
  localparam int TRACK_W      = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         value,
  input  logic               tick,
  output logic               wr_en,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  addr,
  output logic [TRACK_W-1:0] track,
  output logic [1:0]         speed,
  output logic               done,
  output logic               clr,
  output logic [2:0]         state,
  output logic [7:0]         led
);

  localparam logic [1:0] SPD_MAX = 2'(MAX_SPD_LOG2);

  logic       key_valid;
  logic [3:0] key_code;

  key_oneshot u_key (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [TRACK_W-1:0] track_q, track_d;
  logic [1:0]         speed_q, speed_d;
  logic               done_q, done_d;
  logic               clr_q, clr_d;
  logic [ADDR_W:0]    len_q [N_TRACKS];
  logic [ADDR_W:0]    len_d [N_TRACKS];

  logic [TRACK_W-1:0] track_nx;
  logic [ADDR_W+1:0]  ptr_ext, step, len_cur;
  logic               auto_evt;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    track_d  = track_q;
    speed_d  = speed_q;
    done_d   = 1'b0;
    clr_d    = 1'b0;
    auto_evt = 1'b0;
    for (int unsigned i = 0; i < N_TRACKS; i++) begin
      len_d[i] = len_q[i];
    end

    track_nx = (track_q == TRACK_W'(N_TRACKS - 1)) ? '0 : track_q + 1'b1;
    ptr_ext  = {2'b00, ptr_q};
    step     = (ADDR_W + 2)'(1) << speed_q;
    len_cur  = {1'b0, len_q[track_q]};

    // Sample-tick access first: it moves the pointer and may force READY
    // (track full or boundary). A forced transition swallows any key.
    if (tick) begin
      case (state_q)
        ST_REC: begin
          if (ptr_q == '1) begin
            len_d[track_q] = {1'b1, {ADDR_W{1'b0}}};
            state_d        = ST_READY;
            ptr_d          = '0;
            auto_evt       = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        ST_PLAY, ST_FWD: begin
          if (ptr_ext + step >= len_cur) begin
            auto_evt = 1'b1;
          end else begin
            ptr_d = ptr_q + step[ADDR_W-1:0];
          end
        end
        ST_BWD: begin
          if (ptr_ext < step) begin
            auto_evt = 1'b1;
          end else begin
            ptr_d = ptr_q - step[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
      if (auto_evt && state_q != ST_REC) begin
        done_d  = 1'b1;
        state_d = ST_READY;
        ptr_d   = '0;
        speed_d = '0;
      end
    end

    // Key handling sees the pointer as already updated by this cycle's tick.
    if (key_valid && !auto_evt) begin
      case (state_q)
        ST_IDLE: begin
          if (key_code == KEY_ON) begin
            state_d = ST_REC;
            ptr_d   = '0;
          end else if (key_code == KEY_TRACK) begin
            track_d = track_nx;
            state_d = (len_q[track_nx] != '0) ? ST_READY : ST_IDLE;
          end
        end
        ST_REC: begin
          if (key_code == KEY_ON) begin
            len_d[track_q] = {1'b0, ptr_d};
            state_d        = ST_READY;
          end else if (key_code == KEY_PAUSE) begin
            state_d = ST_REC_PAUSE;
          end
        end
        ST_REC_PAUSE: begin
          if (key_code == KEY_ON || key_code == KEY_PAUSE) begin
            state_d = ST_REC;
          end
        end
        ST_READY: begin
          case (key_code)
            KEY_ON: begin
              state_d = ST_PLAY;
              ptr_d   = '0;
            end
            KEY_CLEAR: begin
              len_d[track_q] = '0;
              clr_d          = 1'b1;
              state_d        = ST_IDLE;
            end
            KEY_BACK:  state_d = ST_IDLE;
            KEY_TRACK: begin
              track_d = track_nx;
              state_d = (len_q[track_nx] != '0) ? ST_READY : ST_IDLE;
            end
            default: ;
          endcase
        end
        ST_PLAY: begin
          case (key_code)
            KEY_ON:    state_d = ST_READY;
            KEY_PAUSE: state_d = ST_PLAY_PAUSE;
            KEY_CLEAR: begin
              state_d = ST_FWD;
              speed_d = 2'd1;
            end
            KEY_BACK: begin
              state_d = ST_BWD;
              speed_d = 2'd1;
            end
            default: ;
          endcase
        end
        ST_PLAY_PAUSE: begin
          if (key_code == KEY_ON || key_code == KEY_PAUSE) begin
            state_d = ST_PLAY;
          end
        end
        ST_FWD, ST_BWD: begin
          case (key_code)
            KEY_ON: begin
              state_d = ST_PLAY;
              speed_d = '0;
            end
            KEY_CLEAR: begin
              if (state_q == ST_FWD) begin
                speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 2'd1;
              end else begin
                state_d = ST_FWD;
                speed_d = 2'd1;
              end
            end
            KEY_BACK: begin
              if (state_q == ST_BWD) begin
                speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 2'd1;
              end else begin
                state_d = ST_BWD;
                speed_d = 2'd1;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      track_q <= '0;
      speed_q <= '0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      for (int unsigned i = 0; i < N_TRACKS; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      track_q <= track_d;
      speed_q <= speed_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      for (int unsigned i = 0; i < N_TRACKS; i++) begin
        len_q[i] <= len_d[i];
      end
    end
  end

  always_comb begin
    wr_en = tick && (state_q == ST_REC);
    rd_en = tick && (state_q == ST_PLAY || state_q == ST_FWD || state_q == ST_BWD);
    addr  = ptr_q;
    track = track_q;
    speed = speed_q;
    done  = done_q;
    clr   = clr_q;
    state = state_q;
    led   = led_onehot(state_q);
  end

endmodule

// File: tb/tb_rec_ctrl_mt.sv
module tb_rec_ctrl_mt;

  localparam int AW    = 12;
  localparam int NT    = 4;
  localparam int MS    = 2;
  localparam int DEPTH = 1 << AW;

  // spec state codes used by the reference model
  localparam int M_IDLE = 0, M_REC = 1, M_RECP = 2, M_READY = 3;
  localparam int M_PLAY = 4, M_PLAYP = 5, M_FWD = 6, M_BWD = 7;

  logic        clk = 1'b0;
  logic        rst, tick;
  logic [3:0]  value;
  logic        wr_en, rd_en, done, clr;
  logic [AW-1:0] addr;
  logic [1:0]  track, speed;
  logic [2:0]  state;
  logic [7:0]  led;

  logic        s_rst, s_tick;
  logic [3:0]  s_value;
  logic        s_wr_en, s_rd_en, s_done, s_clr;
  logic [2:0]  s_addr;
  logic [1:0]  s_track, s_speed;
  logic [2:0]  s_state;
  logic [7:0]  s_led;

  int checks = 0;
  int failures = 0;

  // reference model
  int m_state, m_ptr, m_track, m_speed;
  int m_len [NT];
  bit m_armed, m_done, m_clr;

  always #5 clk = ~clk;

  rec_ctrl_mt #(.ADDR_W(AW), .N_TRACKS(NT), .MAX_SPD_LOG2(MS)) u_dut (
    .clk(clk), .rst(rst), .value(value), .tick(tick),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .track(track), .speed(speed),
    .done(done), .clr(clr), .state(state), .led(led)
  );

  rec_ctrl_mt #(.ADDR_W(3), .N_TRACKS(NT), .MAX_SPD_LOG2(MS)) u_small (
    .clk(clk), .rst(s_rst), .value(s_value), .tick(s_tick),
    .wr_en(s_wr_en), .rd_en(s_rd_en), .addr(s_addr), .track(s_track), .speed(s_speed),
    .done(s_done), .clr(s_clr), .state(s_state), .led(s_led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_ptr = 0; m_track = 0; m_speed = 0;
    m_armed = 1; m_done = 0; m_clr = 0;
    for (int i = 0; i < NT; i++) m_len[i] = 0;
  endtask

  task automatic end_of_track();
    m_done = 1; m_state = M_READY; m_ptr = 0; m_speed = 0;
  endtask

  task automatic next_track();
    m_track = (m_track + 1) % NT;
    m_state = (m_len[m_track] != 0) ? M_READY : M_IDLE;
  endtask

  // One clock cycle on the main DUT: drive, compare against model, advance model.
  task automatic step(input logic [3:0] v, input logic t, input logic r);
    int  key;
    int  stp;
    bit  forced;
    @(negedge clk);
    rst = r; value = v; tick = t;
    #1;
    chk("state", 32'(state), m_state);
    chk("addr",  32'(addr),  m_ptr);
    chk("track", 32'(track), m_track);
    chk("speed", 32'(speed), m_speed);
    chk("done",  32'(done),  32'(m_done));
    chk("clr",   32'(clr),   32'(m_clr));
    chk("led",   32'(led),   32'(1) << m_state);
    chk("wr_en", 32'(wr_en), 32'(t && m_state == M_REC));
    chk("rd_en", 32'(rd_en), 32'(t && (m_state == M_PLAY || m_state == M_FWD || m_state == M_BWD)));
    if (r) begin
      model_reset();
      return;
    end
    key     = (m_armed && v != 4'hF) ? int'(v) : 0;
    m_armed = (v == 4'hF);
    m_done  = 0;
    m_clr   = 0;
    forced  = 0;
    stp     = 1 << m_speed;
    if (t) begin
      if (m_state == M_REC) begin
        if (m_ptr == DEPTH - 1) begin
          m_len[m_track] = DEPTH; m_state = M_READY; m_ptr = 0; forced = 1;
        end else m_ptr++;
      end else if (m_state == M_PLAY || m_state == M_FWD) begin
        if (m_ptr + stp >= m_len[m_track]) begin end_of_track(); forced = 1; end
        else m_ptr += stp;
      end else if (m_state == M_BWD) begin
        if (m_ptr < stp) begin end_of_track(); forced = 1; end
        else m_ptr -= stp;
      end
    end
    if (!forced && key != 0) begin
      if (m_state == M_IDLE) begin
        if (key == 1) begin m_state = M_REC; m_ptr = 0; end
        else if (key == 5) next_track();
      end else if (m_state == M_REC) begin
        if (key == 1) begin m_len[m_track] = m_ptr; m_state = M_READY; end
        else if (key == 2) m_state = M_RECP;
      end else if (m_state == M_RECP) begin
        if (key == 1 || key == 2) m_state = M_REC;
      end else if (m_state == M_READY) begin
        if (key == 1) begin m_state = M_PLAY; m_ptr = 0; end
        else if (key == 3) begin m_len[m_track] = 0; m_clr = 1; m_state = M_IDLE; end
        else if (key == 4) m_state = M_IDLE;
        else if (key == 5) next_track();
      end else if (m_state == M_PLAY) begin
        if (key == 1) m_state = M_READY;
        else if (key == 2) m_state = M_PLAYP;
        else if (key == 3) begin m_state = M_FWD; m_speed = 1; end
        else if (key == 4) begin m_state = M_BWD; m_speed = 1; end
      end else if (m_state == M_PLAYP) begin
        if (key == 1 || key == 2) m_state = M_PLAY;
      end else begin
        // FWD or BWD
        if (key == 1) begin m_state = M_PLAY; m_speed = 0; end
        else if ((key == 3 && m_state == M_FWD) || (key == 4 && m_state == M_BWD))
          m_speed = (m_speed + 1 > MS) ? MS : m_speed + 1;
        else if (key == 3) begin m_state = M_FWD; m_speed = 1; end
        else if (key == 4) begin m_state = M_BWD; m_speed = 1; end
      end
    end
  endtask

  task automatic key(input logic [3:0] k);
    step(k, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
  endtask

  task automatic sstep(input logic [3:0] v, input logic t);
    @(negedge clk);
    s_value = v; s_tick = t;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; value = 4'hF; tick = 1'b0;
    s_rst = 1'b1; s_value = 4'hF; s_tick = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // reset state
    step(4'hF, 1'b0, 1'b0);
    chk("reset_led", 32'(led), 32'h01);

    // record 10 samples on track 0
    key(4'h1);
    repeat (10) step(4'hF, 1'b1, 1'b0);
    key(4'h1);
    chk("rec_state", 32'(state), 3);
    chk("rec_led", 32'(led), 32'h08);

    // play back to the end
    key(4'h1);
    repeat (10) step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    chk("play_done", 32'(done), 1);
    chk("play_end_state", 32'(state), 3);

    // track 1: record 20, then fast-forward with saturating speed
    key(4'h5);
    key(4'h1);
    repeat (20) step(4'hF, 1'b1, 1'b0);
    key(4'h1);
    key(4'h1);
    repeat (4) step(4'hF, 1'b1, 1'b0);
    key(4'h3);
    chk("fwd_speed1", 32'(speed), 1);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    key(4'h3);
    chk("fwd_speed2", 32'(speed), 2);
    step(4'hF, 1'b1, 1'b0);
    key(4'h3);
    chk("fwd_speed_sat", 32'(speed), 2);
    chk("fwd_addr", 32'(addr), 12);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    chk("fwd_done", 32'(done), 1);

    // rewind from ptr 3 at speed 1
    key(4'h1);
    repeat (3) step(4'hF, 1'b1, 1'b0);
    key(4'h4);
    chk("bwd_state", 32'(state), 7);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    chk("bwd_done", 32'(done), 1);
    chk("bwd_addr", 32'(addr), 0);

    // held TRACK_NEXT advances once
    repeat (20) step(4'h5, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    chk("hold_track", 32'(track), 2);
    key(4'h5);
    key(4'h5);
    chk("wrap_track", 32'(track), 0);
    key(4'h3);
    chk("clr_pulse", 32'(clr), 1);
    chk("clr_state", 32'(state), 0);

    // reset mid-play clears lengths
    key(4'h5);
    key(4'h1);
    repeat (5) step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0);
    chk("rst_state", 32'(state), 0);
    key(4'h5);
    chk("rst_len_state", 32'(state), 0);
    chk("rst_len_track", 32'(track), 1);

    // randomized phase against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v;
      logic       t, r;
      v = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 7)) : 4'hF;
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 499) == 0);
      step(v, t, r);
    end
    step(4'hF, 1'b0, 1'b0);

    // small instance (ADDR_W=3): fill the track and auto-stop
    @(negedge clk);
    s_rst = 1'b0;
    sstep(4'h1, 1'b0);
    sstep(4'hF, 1'b0);
    chk("s_rec_state", 32'(s_state), 1);
    for (int i = 0; i < 10; i++) begin
      sstep(4'hF, 1'b1);
      if (i < 8) begin
        chk("s_wr_en", 32'(s_wr_en), 1);
        chk("s_wr_addr", 32'(s_addr), i);
      end else begin
        chk("s_wr_en_full", 32'(s_wr_en), 0);
        chk("s_full_state", 32'(s_state), 3);
      end
    end
    sstep(4'hF, 1'b0);
    chk("s_led", 32'(s_led), 32'h08);
    sstep(4'h1, 1'b0);
    sstep(4'hF, 1'b0);
    chk("s_play_state", 32'(s_state), 4);
    for (int i = 0; i < 8; i++) begin
      sstep(4'hF, 1'b1);
      chk("s_rd_en", 32'(s_rd_en), 1);
      chk("s_rd_addr", 32'(s_addr), i);
    end
    sstep(4'hF, 1'b0);
    chk("s_done", 32'(s_done), 1);
    chk("s_end_state", 32'(s_state), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
